// File: rtl/mem_rsp_pkg.sv
// rtl/mem_rsp_pkg.sv - shared op encoding and helpers for the memory response controller
package mem_rsp_pkg;

  typedef enum logic [1:0] {OP_NOP, OP_WR, OP_RD, OP_ERR} op_e;

  // Number of byte lanes in a data word.
  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

  // A request asking for both read and write is an error, never a partial op.
  function automatic op_e decode_op(input logic wr_en, input logic rd_en);
    case ({wr_en, rd_en})
      2'b10:   return OP_WR;
      2'b01:   return OP_RD;
      2'b11:   return OP_ERR;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/mem_rsp_fifo.sv
// rtl/mem_rsp_fifo.sv - first-word-fall-through response queue with occupancy count
module mem_rsp_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

  // Storage, pointers and count; a full queue may push only when popping the same edge.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push_i && !do_pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!push_i && do_pop) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Upstream credit must make overflow unreachable.
  always_ff @(posedge clk_i) begin
    if (resetn_i && push_i && !do_pop) begin
      a_no_overflow: assert (count_q < CNT_W'(DEPTH));
    end
  end

endmodule

// File: rtl/mem_rsp_ctrl.sv
// rtl/mem_rsp_ctrl.sv - single-port memory with byte strobes, fixed read latency and credited response queue
module mem_rsp_ctrl
  import mem_rsp_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int RD_LAT    = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rdata,
  output logic                rsp_err
);

  localparam int STRB_W = strb_w(DATA_W);
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int CNT_W  = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] data;
  } rsp_t;

  if (ADDR_W < 2 || ADDR_W > 8) begin : g_bad_addr_w
    $error("ADDR_W must be in 2..8");
  end
  if (DATA_W % 8 != 0 || DATA_W == 0) begin : g_bad_data_w
    $error("DATA_W must be a non-zero multiple of 8");
  end
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("RD_LAT must be in 1..4");
  end
  if (RSP_DEPTH < RD_LAT + 1) begin : g_bad_depth
    $error("RSP_DEPTH must be at least RD_LAT+1");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]  outstanding_q;
  logic [CNT_W-1:0]  outstanding_d;
  logic [CNT_W-1:0]  fifo_cnt;
  op_e               op;
  logic              accept;
  logic              in_v;
  rsp_t              in_rsp;
  logic              push;
  rsp_t              push_rsp;
  rsp_t              head;
  logic              pop;

  // Credit covers tokens in the pipe as well as the queue, so a pop is only credited next cycle.
  assign req_ready = reset && (outstanding_q < CNT_W'(RSP_DEPTH));

  // Decode the accepted request and form the token that enters the read pipe.
  always_comb begin
    op          = decode_op(wr_en, rd_en);
    accept      = req_valid && req_ready;
    in_v        = accept && (op == OP_RD || op == OP_ERR);
    in_rsp.err  = (op == OP_ERR);
    in_rsp.data = (op == OP_RD) ? mem_q[addr] : '0;
  end

  // Memory array: cleared on reset, byte-masked write on an accepted write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (accept && op == OP_WR) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) begin
          mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  if (RD_LAT == 1) begin : g_no_pipe
    assign push     = in_v;
    assign push_rsp = in_rsp;
  end else begin : g_pipe
    logic [RD_LAT-2:0] pipe_v_q;
    rsp_t              pipe_rsp_q [RD_LAT-1];

    // Token valids shift one stage per clock and are flushed by reset.
    always_ff @(posedge clk) begin
      if (!reset) begin
        pipe_v_q <= '0;
      end else begin
        pipe_v_q[0] <= in_v;
        for (int s = 1; s < RD_LAT - 1; s++) begin
          pipe_v_q[s] <= pipe_v_q[s-1];
        end
      end
    end

    // Token payloads follow their valids; stale payloads are harmless.
    always_ff @(posedge clk) begin
      pipe_rsp_q[0] <= in_rsp;
      for (int s = 1; s < RD_LAT - 1; s++) begin
        pipe_rsp_q[s] <= pipe_rsp_q[s-1];
      end
    end

    assign push     = pipe_v_q[RD_LAT-2];
    assign push_rsp = pipe_rsp_q[RD_LAT-2];
  end

  mem_rsp_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i       (clk),
    .resetn_i    (reset),
    .push_i      (push),
    .push_data_i (push_rsp),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_cnt)
  );

  assign rsp_valid = (fifo_cnt != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rdata     = head.data;
  assign rsp_err   = head.err;

  // Next outstanding count: +1 per read/error token, -1 per pop.
  always_comb begin
    outstanding_d = outstanding_q;
    if (in_v && !pop) begin
      outstanding_d = outstanding_q + CNT_W'(1);
    end else if (!in_v && pop) begin
      outstanding_d = outstanding_q - CNT_W'(1);
    end
  end

  // Outstanding credit register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

endmodule

// File: tb/tb_mem_rsp_ctrl.sv
// tb/tb_mem_rsp_ctrl.sv - directed self-checking bench for mem_rsp_ctrl
module tb_mem_rsp_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [3:0]  addr = '0;
  logic [7:0]  wdata = '0;
  logic [0:0]  wstrb = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_err;
  logic [7:0]  rdata;

  logic        w_req_valid = 1'b0;
  logic        w_wr_en = 1'b0;
  logic        w_rd_en = 1'b0;
  logic        w_rsp_ready = 1'b0;
  logic [3:0]  w_addr = '0;
  logic [15:0] w_wdata = '0;
  logic [1:0]  w_wstrb = '0;
  logic        w_req_ready;
  logic        w_rsp_valid;
  logic        w_rsp_err;
  logic [15:0] w_rdata;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_rsp_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .addr(addr), .wr_en(wr_en), .rd_en(rd_en), .wdata(wdata), .wstrb(wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rdata(rdata), .rsp_err(rsp_err)
  );

  mem_rsp_ctrl #(.DATA_W(16)) dut16 (
    .clk(clk), .reset(reset), .req_valid(w_req_valid), .req_ready(w_req_ready),
    .addr(w_addr), .wr_en(w_wr_en), .rd_en(w_rd_en), .wdata(w_wdata), .wstrb(w_wstrb),
    .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready), .rdata(w_rdata), .rsp_err(w_rsp_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic wr, input logic rd, input logic [3:0] a,
                      input logic [7:0] d, input logic s);
    req_valid = 1'b1; wr_en = wr; rd_en = rd; addr = a; wdata = d; wstrb = s;
    step();
    req_valid = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic pop_one();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    n_checks++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready: got %b want 0", req_ready); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if (rdata !== 8'h00) $display("FAIL reset_rdata: got %h want 00", rdata); else n_pass++;
    n_checks++; if (rsp_err !== 1'b0) $display("FAIL reset_rsp_err: got %b want 0", rsp_err); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL release_req_ready: got %b want 1", req_ready); else n_pass++;
  endtask

  task automatic test_read_latency();
    send(1'b0, 1'b1, 4'd5, 8'h00, 1'b0);
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL lat_early: got %b want 0", rsp_valid); else n_pass++;
    step();
    n_checks++; if (rsp_valid !== 1'b1) $display("FAIL lat_valid: got %b want 1", rsp_valid); else n_pass++;
    n_checks++; if (rdata !== 8'h00) $display("FAIL lat_rdata: got %h want 00", rdata); else n_pass++;
    n_checks++; if (rsp_err !== 1'b0) $display("FAIL lat_err: got %b want 0", rsp_err); else n_pass++;
    pop_one();
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL lat_popped: got %b want 0", rsp_valid); else n_pass++;
  endtask

  task automatic test_write_strobe();
    send(1'b1, 1'b0, 4'd3, 8'hA5, 1'b1);
    send(1'b1, 1'b0, 4'd3, 8'hFF, 1'b0);
    send(1'b0, 1'b1, 4'd3, 8'h00, 1'b0);
    step();
    n_checks++; if (rsp_valid !== 1'b1) $display("FAIL strb_valid: got %b want 1", rsp_valid); else n_pass++;
    n_checks++; if (rdata !== 8'hA5) $display("FAIL strb_rdata: got %h want a5", rdata); else n_pass++;
    step();
    n_checks++; if (rdata !== 8'hA5 || rsp_valid !== 1'b1) $display("FAIL strb_hold: got %h/%b want a5/1", rdata, rsp_valid); else n_pass++;
    pop_one();
  endtask

  task automatic test_wide();
    w_req_valid = 1'b1; w_wr_en = 1'b1; w_addr = 4'd2; w_wdata = 16'hBEEF; w_wstrb = 2'b11;
    step();
    w_wdata = 16'h1234; w_wstrb = 2'b01;
    step();
    w_wr_en = 1'b0; w_rd_en = 1'b1;
    step();
    w_req_valid = 1'b0; w_rd_en = 1'b0;
    step();
    n_checks++; if (w_rsp_valid !== 1'b1) $display("FAIL wide_valid: got %b want 1", w_rsp_valid); else n_pass++;
    n_checks++; if (w_rdata !== 16'hBE34) $display("FAIL wide_rdata: got %h want be34", w_rdata); else n_pass++;
    w_rsp_ready = 1'b1;
    step();
    w_rsp_ready = 1'b0;
  endtask

  task automatic test_illegal();
    send(1'b1, 1'b0, 4'd7, 8'h3C, 1'b1);
    send(1'b1, 1'b1, 4'd7, 8'hFF, 1'b1);
    step();
    n_checks++; if (rsp_valid !== 1'b1) $display("FAIL err_valid: got %b want 1", rsp_valid); else n_pass++;
    n_checks++; if (rsp_err !== 1'b1) $display("FAIL err_flag: got %b want 1", rsp_err); else n_pass++;
    n_checks++; if (rdata !== 8'h00) $display("FAIL err_rdata: got %h want 00", rdata); else n_pass++;
    pop_one();
    send(1'b0, 1'b1, 4'd7, 8'h00, 1'b0);
    step();
    n_checks++; if (rsp_err !== 1'b0) $display("FAIL err_follow_flag: got %b want 0", rsp_err); else n_pass++;
    n_checks++; if (rdata !== 8'h3C) $display("FAIL err_follow_rdata: got %h want 3c", rdata); else n_pass++;
    pop_one();
  endtask

  task automatic test_backpressure();
    int accepted;
    for (int k = 0; k < 4; k++) send(1'b1, 1'b0, 4'(k), 8'(16 + k), 1'b1);
    rsp_ready = 1'b0; accepted = 0;
    req_valid = 1'b1; rd_en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      addr = 4'(accepted);
      if (req_ready) accepted++;
      step();
    end
    req_valid = 1'b0; rd_en = 1'b0;
    n_checks++; if (accepted != 4) $display("FAIL bp_accepted: got %0d want 4", accepted); else n_pass++;
    n_checks++; if (req_ready !== 1'b0) $display("FAIL bp_ready_low: got %b want 0", req_ready); else n_pass++;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rdata !== 8'(16 + k))
        $display("FAIL bp_order[%0d]: got %h/%b want %h/1", k, rdata, rsp_valid, 8'(16 + k));
      else n_pass++;
      if (k == 0) begin
        n_checks++; if (req_ready !== 1'b0) $display("FAIL bp_no_early_credit: got %b want 0", req_ready); else n_pass++;
      end
      step();
      if (k == 0) begin
        n_checks++; if (req_ready !== 1'b1) $display("FAIL bp_ready_return: got %b want 1", req_ready); else n_pass++;
      end
    end
    rsp_ready = 1'b0;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL bp_drained: got %b want 0", rsp_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int drops;
    int nrsp;
    for (int k = 0; k < 16; k++) send(1'b1, 1'b0, 4'(k), 8'(192 + k), 1'b1);
    drops = 0; nrsp = 0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c < 16) begin
        req_valid = 1'b1; rd_en = 1'b1; addr = 4'(c);
        if (!req_ready) drops++;
      end else begin
        req_valid = 1'b0; rd_en = 1'b0;
      end
      if (rsp_valid) begin
        n_checks++;
        if (rdata !== 8'(192 + nrsp) || rsp_err !== 1'b0)
          $display("FAIL b2b_rsp[%0d]: got %h/%b want %h/0", nrsp, rdata, rsp_err, 8'(192 + nrsp));
        else n_pass++;
        nrsp++;
      end
      step();
    end
    rsp_ready = 1'b0;
    n_checks++; if (drops != 0) $display("FAIL b2b_ready_drops: got %0d want 0", drops); else n_pass++;
    n_checks++; if (nrsp != 16) $display("FAIL b2b_rsp_count: got %0d want 16", nrsp); else n_pass++;
  endtask

  task automatic test_reset_midop();
    int stale;
    rsp_ready = 1'b0;
    req_valid = 1'b1; rd_en = 1'b1;
    addr = 4'd1; step();
    addr = 4'd2; step();
    addr = 4'd3; step();
    req_valid = 1'b0; rd_en = 1'b0;
    step();
    n_checks++; if (rsp_valid !== 1'b1) $display("FAIL mid_pending: got %b want 1", rsp_valid); else n_pass++;
    reset = 1'b0;
    step();
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL mid_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if (rdata !== 8'h00) $display("FAIL mid_rdata: got %h want 00", rdata); else n_pass++;
    n_checks++; if (req_ready !== 1'b0) $display("FAIL mid_req_ready: got %b want 0", req_ready); else n_pass++;
    reset = 1'b1;
    rsp_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid) stale++;
      step();
    end
    rsp_ready = 1'b0;
    n_checks++; if (stale != 0) $display("FAIL mid_stale: got %0d want 0", stale); else n_pass++;
    send(1'b0, 1'b1, 4'd1, 8'h00, 1'b0);
    step();
    n_checks++; if (rsp_valid !== 1'b1 || rdata !== 8'h00) $display("FAIL mid_mem_cleared: got %h/%b want 00/1", rdata, rsp_valid); else n_pass++;
    pop_one();
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_write_strobe();
    test_wide();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
